// File: rtl/lfsr_frame_checker.sv
// Serial frame-header checker: regenerates the expected header from a stored LFSR seed
// and classifies the number of mismatching bits. Optional macro ERR_COUNT_OUT_EN adds res_errs.
module lfsr_frame_checker #(
  parameter int                FRAME_W  = 32,
  parameter int                LFSR_W   = 5,
  parameter logic [LFSR_W-1:0] TAPS     = 5'b01001,
  parameter logic [LFSR_W-1:0] SEED_RST = 5'b00001,
  parameter bit                ZERO_MSB = 1'b1,
  parameter int                CNT_W    = $clog2(FRAME_W + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FRAME_W-1:0] in_frame,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [1:0]         res_class,
  output logic               busy
`ifdef ERR_COUNT_OUT_EN
  ,
  output logic [CNT_W-1:0]   res_errs
`endif
);

  // state   | meaning
  // IDLE    | waiting for a frame; seed register writable
  // CHECK   | comparing one latched bit per cycle against the LFSR output
  // REPORT  | result held on res_class until res_ready
  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_REPORT} state_t;

  localparam int IDX_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_W - 1);

  state_t             state;
  logic [LFSR_W-1:0]  seed_q;
  logic [LFSR_W-1:0]  sr;
  logic [FRAME_W-1:0] frame_q;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   err_cnt;

  logic             fb;
  logic             exp_bit;
  logic             mismatch;
  logic [CNT_W-1:0] cnt_final;

  function automatic logic [1:0] classify(input logic [CNT_W-1:0] n);
    if (n == CNT_W'(0))      return 2'b00;
    else if (n == CNT_W'(1)) return 2'b01;
    else if (n == CNT_W'(2)) return 2'b10;
    else                     return 2'b11;
  endfunction

  always_comb begin
    fb      = ^(sr & TAPS);
    exp_bit = sr[0];
    if (ZERO_MSB && (idx == IDX_LAST)) exp_bit = 1'b0;
    mismatch  = frame_q[idx] ^ exp_bit;
    cnt_final = err_cnt + CNT_W'(mismatch);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      seed_q    <= SEED_RST;
      sr        <= '0;
      frame_q   <= '0;
      idx       <= '0;
      err_cnt   <= '0;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
      res_class <= 2'b11;
      busy      <= 1'b0;
`ifdef ERR_COUNT_OUT_EN
      res_errs  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (seed_load) seed_q <= seed;
          if (in_valid) begin
            frame_q  <= in_frame;
            // a seed written in the same cycle is used for this frame
            sr       <= seed_load ? seed : seed_q;
            idx      <= '0;
            err_cnt  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          sr      <= {fb, sr[LFSR_W-1:1]};
          err_cnt <= cnt_final;
          idx     <= idx + 1'b1;
          if (idx == IDX_LAST) begin
            res_class <= classify(cnt_final);
`ifdef ERR_COUNT_OUT_EN
            res_errs  <= cnt_final;
`endif
            res_valid <= 1'b1;
            state     <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_frame_checker.sv
// Directed bench for lfsr_frame_checker with a cycle-level reference model and per-cycle compare.
module tb_lfsr_frame_checker;
  localparam int FRAME_W = 32;
  localparam int LFSR_W  = 5;
  localparam logic [LFSR_W-1:0] TAPS     = 5'b01001;
  localparam logic [LFSR_W-1:0] SEED_RST = 5'b00001;
  localparam int CNT_W = $clog2(FRAME_W + 1);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               seed_load;
  logic [LFSR_W-1:0]  seed;
  logic               in_valid;
  logic               in_ready;
  logic [FRAME_W-1:0] in_frame;
  logic               res_valid;
  logic               res_ready;
  logic [1:0]         res_class;
  logic               busy;
`ifdef ERR_COUNT_OUT_EN
  logic [CNT_W-1:0]   res_errs;
`endif

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  lfsr_frame_checker dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_frame(in_frame),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
    .busy(busy)
`ifdef ERR_COUNT_OUT_EN
    , .res_errs(res_errs)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // expected header: LFSR output stream, bit 0 first, MSB optionally forced low
  function automatic logic [FRAME_W-1:0] header(input logic [LFSR_W-1:0] s0);
    logic [FRAME_W-1:0] h;
    logic [LFSR_W-1:0]  s;
    s = s0;
    h = '0;
    for (int i = 0; i < FRAME_W; i++) begin
      h[i] = s[0];
      s = {^(s & TAPS), s[LFSR_W-1:1]};
    end
    h[FRAME_W-1] = 1'b0;
    return h;
  endfunction

  function automatic logic [1:0] cls(input int n);
    return (n >= 3) ? 2'd3 : 2'(n);
  endfunction

  // reference model: remaining-cycles counter plus pending error count
  logic [LFSR_W-1:0] m_seed;
  int                m_rem;
  int                m_pend;
  logic              m_valid;
  logic [1:0]        m_class;
  int                m_errs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_seed  <= SEED_RST;
      m_rem   <= 0;
      m_pend  <= 0;
      m_valid <= 1'b0;
      m_class <= 2'b11;
      m_errs  <= 0;
    end else if (m_valid) begin
      if (res_ready) m_valid <= 1'b0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_valid <= 1'b1;
        m_class <= cls(m_pend);
        m_errs  <= m_pend;
      end
    end else begin
      if (seed_load) m_seed <= seed;
      if (in_valid) begin
        m_pend <= $countones(in_frame ^ header(seed_load ? seed : m_seed));
        m_rem  <= FRAME_W;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_in_ready",  64'(in_ready),  64'(!m_valid && m_rem == 0));
      chk("cmp_busy",      64'(busy),      64'(m_valid || m_rem != 0));
      chk("cmp_res_valid", 64'(res_valid), 64'(m_valid));
      chk("cmp_res_class", 64'(res_class), 64'(m_class));
`ifdef ERR_COUNT_OUT_EN
      chk("cmp_res_errs",  64'(res_errs),  64'(m_errs));
`endif
    end
  end

  task automatic accept(input logic [FRAME_W-1:0] f, input logic ld, input logic [LFSR_W-1:0] sd);
    @(posedge clk); #1;
    in_valid = 1'b1; in_frame = f; seed_load = ld; seed = sd;
    @(posedge clk); #1;
    in_valid = 1'b0; seed_load = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [1:0] exp_class, input int exp_errs);
    int n;
    n = 0;
    while (!res_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(FRAME_W));
    chk({name, "_class"}, 64'(res_class), 64'(exp_class));
`ifdef ERR_COUNT_OUT_EN
    chk({name, "_errs"}, 64'(res_errs), 64'(exp_errs));
`else
    if (exp_errs < 0) $display("note: negative error count requested");
`endif
  endtask

  task automatic run_frame(input string name, input logic [FRAME_W-1:0] f, input logic ld,
                           input logic [LFSR_W-1:0] sd, input logic [1:0] exp_class, input int exp_errs);
    accept(f, ld, sd);
    wait_result(name, exp_class, exp_errs);
  endtask

  task automatic seed_pulse(input logic [LFSR_W-1:0] sd);
    @(posedge clk); #1;
    seed_load = 1'b1; seed = sd;
    @(posedge clk); #1;
    seed_load = 1'b0;
  endtask

  initial begin
    logic [1:0] held_class;
    int seen;
    rst_n = 1'b0; seed_load = 1'b0; seed = '0; in_valid = 1'b0; in_frame = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_class", 64'(res_class), 64'd3);
    chk("rst_busy",      64'(busy),      64'd0);
`ifdef ERR_COUNT_OUT_EN
    chk("rst_res_errs",  64'(res_errs),  64'd0);
`endif
    chk("model_header_seed1", 64'(header(5'b00001)), 64'h167C6EA1);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    seed_pulse(5'b00001);
    run_frame("exact",   32'h167C6EA1, 1'b0, '0, 2'b00, 0);
    run_frame("one_bit", 32'h167C6EA0, 1'b0, '0, 2'b01, 1);
    run_frame("two_bit", 32'h967C6EA0, 1'b0, '0, 2'b10, 2);
    run_frame("all_inv", 32'hE983915E, 1'b0, '0, 2'b11, 32);

    // seed written in the accepting cycle is used, then retained
    run_frame("load_accept", header(5'h1F), 1'b1, 5'h1F, 2'b00, 0);
    run_frame("kept_seed", header(5'h1F) ^ 32'h0000_0111, 1'b0, '0, 2'b11, 3);

    seed_pulse(5'b00000);
    run_frame("zero_seed", 32'h0000_0000, 1'b0, '0, 2'b00, 0);
    run_frame("zero_msb",  32'h8000_0000, 1'b0, '0, 2'b01, 1);
    seed_pulse(5'b00001);

    // stall in REPORT; inputs during the stall must be ignored
    res_ready = 1'b0;
    run_frame("stall", 32'h167C6EA0, 1'b0, '0, 2'b01, 1);
    held_class = res_class;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_frame = 32'hFFFF_FFFF; seed_load = 1'b1; seed = 5'h1F;
      chk("stall_valid", 64'(res_valid), 64'd1);
      chk("stall_class", 64'(res_class), 64'(held_class));
      chk("stall_ready", 64'(in_ready),  64'd0);
    end
    in_valid = 1'b0; seed_load = 1'b0; res_ready = 1'b1;
    run_frame("after_stall", 32'h167C6EA1, 1'b0, '0, 2'b00, 0);

    // reset in the middle of CHECK
    seed_pulse(5'h1F);
    accept(32'h167C6EA1, 1'b0, '0);
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  64'(in_ready),  64'd1);
    chk("midrst_res_valid", 64'(res_valid), 64'd0);
    chk("midrst_res_class", 64'(res_class), 64'd3);
    chk("midrst_busy",      64'(busy),      64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (res_valid) seen++;
    end
    chk("midrst_no_result", 64'(seen), 64'd0);
    run_frame("seed_after_rst", 32'h167C6EA1, 1'b0, '0, 2'b00, 0);

    @(posedge clk); #1;
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
